// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite subordinate adaptor.
//   axil_state_e : adaptor FSM states
//   axil_resp_e  : AXI response codes the adaptor can generate
package axil_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_req  = 2'd1,
        e_wait = 2'd2,
        e_resp = 2'd3
    } axil_state_e;

    typedef enum logic [1:0] {
        e_axil_resp_okay   = 2'b00,
        e_axil_resp_slverr = 2'b10
    } axil_resp_e;

    localparam logic [2:0] e_axi_prot_default = 3'b000;

endpackage

// File: rtl/axil_chan_buf.sv
// One-entry channel buffer with full flag.
//   v_i/ready_o/data_i : upstream valid/ready handshake; ready_o = ~full
//   full_o/data_o      : buffered payload for the consumer
//   yumi_i             : consumer frees the entry
// ready_o is registered, so there is no path from v_i to ready_o and a freed
// entry only reopens on the following cycle. ready_o is low during reset.
module axil_chan_buf #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic               r_full;
    logic               r_ready;
    logic [width_p-1:0] r_data;
    logic               w_hs;
    logic               w_full_n;

    assign w_hs     = v_i & r_ready;
    assign w_full_n = w_hs | (r_full & ~yumi_i);

    // Entry state and payload capture
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_full  <= w_full_n;
            r_ready <= ~w_full_n;
            if (w_hs) begin
                r_data <= data_i;
            end
        end
    end

    assign ready_o = r_ready;
    assign full_o  = r_full;
    assign data_o  = r_data;

endmodule

// File: rtl/axil_slave_adaptor.sv
// AXI4-Lite subordinate front end: buffers AW, W and AR independently and
// issues one transaction at a time to a valid/ready host request interface,
// alternating between reads and writes when both are pending.
//   s_axil_*          : AXI4-Lite subordinate port (AxPROT ignored)
//   addr_o .. v_o     : host request (ready_and_i accepts)
//   v_i/rdata_i/err_i : host response (yumi_o consumes)
module axil_slave_adaptor
    import axil_pkg::*;
#(
    parameter int unsigned axil_data_width_p = 32,
    parameter int unsigned axil_addr_width_p = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic [2:0]                     s_axil_awprot_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic [2:0]                     s_axil_arprot_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    output logic [axil_addr_width_p-1:0]   addr_o,
    output logic                           wr_en_o,
    output logic [axil_data_width_p-1:0]   wdata_o,
    output logic [axil_data_width_p/8-1:0] wstrb_o,
    output logic                           v_o,
    input  logic                           ready_and_i,
    input  logic                           v_i,
    input  logic [axil_data_width_p-1:0]   rdata_i,
    input  logic                           err_i,
    output logic                           yumi_o
);

    localparam int unsigned strb_w  = axil_data_width_p / 8;
    localparam int unsigned w_buf_w = axil_data_width_p + strb_w;

    if (axil_data_width_p != 32 && axil_data_width_p != 64) begin : g_bad_width
        $error("axil_slave_adaptor: axil_data_width_p must be 32 or 64");
    end

    axil_state_e                  r_state;
    axil_state_e                  w_state_n;
    logic                         r_is_wr;
    logic                         r_last_wr;
    logic [1:0]                   r_resp;
    logic [axil_data_width_p-1:0] r_rdata;

    logic                         w_aw_ready, w_aw_full, w_aw_hs;
    logic                         w_w_ready,  w_w_full,  w_w_hs;
    logic                         w_ar_ready, w_ar_full, w_ar_hs;
    logic [axil_addr_width_p-1:0] w_aw_addr, w_ar_addr;
    logic [w_buf_w-1:0]           w_w_data;
    logic                         w_wr_avail, w_rd_avail;
    logic                         w_pick_wr, w_latch, w_req_hs, w_rsp_cap;
    logic                         w_unused_prot;

    assign w_unused_prot = |((s_axil_awprot_i | s_axil_arprot_i) ^ e_axi_prot_default);

    // Channel buffers; entries are freed by the host request handshake
    axil_chan_buf #(.width_p(axil_addr_width_p)) u_aw_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (s_axil_awvalid_i),
        .ready_o   (w_aw_ready),
        .data_i    (s_axil_awaddr_i),
        .full_o    (w_aw_full),
        .data_o    (w_aw_addr),
        .yumi_i    (w_req_hs & r_is_wr)
    );

    axil_chan_buf #(.width_p(w_buf_w)) u_w_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (s_axil_wvalid_i),
        .ready_o   (w_w_ready),
        .data_i    ({s_axil_wstrb_i, s_axil_wdata_i}),
        .full_o    (w_w_full),
        .data_o    (w_w_data),
        .yumi_i    (w_req_hs & r_is_wr)
    );

    axil_chan_buf #(.width_p(axil_addr_width_p)) u_ar_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (s_axil_arvalid_i),
        .ready_o   (w_ar_ready),
        .data_i    (s_axil_araddr_i),
        .full_o    (w_ar_full),
        .data_o    (w_ar_addr),
        .yumi_i    (w_req_hs & ~r_is_wr)
    );

    assign w_aw_hs = s_axil_awvalid_i & w_aw_ready;
    assign w_w_hs  = s_axil_wvalid_i  & w_w_ready;
    assign w_ar_hs = s_axil_arvalid_i & w_ar_ready;

    // Count a channel as present in the cycle its handshake completes so the
    // request goes out the cycle after the last AXI handshake.
    assign w_wr_avail = (w_aw_full | w_aw_hs) & (w_w_full | w_w_hs);
    assign w_rd_avail = w_ar_full | w_ar_hs;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next state and transaction controls
    always_comb begin
        w_state_n = r_state;
        w_pick_wr = 1'b0;
        w_latch   = 1'b0;
        w_req_hs  = 1'b0;
        w_rsp_cap = 1'b0;
        case (r_state)
            e_idle: begin
                // Round-robin on ties; otherwise take whichever is pending
                w_pick_wr = (w_wr_avail & w_rd_avail) ? ~r_last_wr : w_wr_avail;
                if (w_wr_avail | w_rd_avail) begin
                    w_latch   = 1'b1;
                    w_state_n = e_req;
                end
            end
            e_req: begin
                if (ready_and_i) begin
                    w_req_hs  = 1'b1;
                    w_state_n = e_wait;
                end
            end
            e_wait: begin
                if (v_i) begin
                    w_rsp_cap = 1'b1;
                    w_state_n = e_resp;
                end
            end
            e_resp: begin
                if (r_is_wr ? s_axil_bready_i : s_axil_rready_i) begin
                    w_state_n = e_idle;
                end
            end
            default: w_state_n = e_idle;
        endcase
    end

    // Transaction bookkeeping and captured response
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_is_wr   <= 1'b0;
            r_last_wr <= 1'b0;
            r_resp    <= e_axil_resp_okay;
            r_rdata   <= '0;
        end else begin
            if (w_latch) begin
                r_is_wr <= w_pick_wr;
            end
            if (w_req_hs) begin
                r_last_wr <= r_is_wr;
            end
            if (w_rsp_cap) begin
                r_rdata <= rdata_i;
                r_resp  <= err_i ? e_axil_resp_slverr : e_axil_resp_okay;
            end
        end
    end

    assign s_axil_awready_o = w_aw_ready;
    assign s_axil_wready_o  = w_w_ready;
    assign s_axil_arready_o = w_ar_ready;

    assign v_o     = (r_state == e_req);
    assign wr_en_o = r_is_wr;
    assign addr_o  = r_is_wr ? w_aw_addr : w_ar_addr;
    assign wdata_o = w_w_data[axil_data_width_p-1:0];
    assign wstrb_o = w_w_data[axil_data_width_p +: strb_w];
    assign yumi_o  = (r_state == e_wait) & v_i;

    assign s_axil_bvalid_o = (r_state == e_resp) &  r_is_wr;
    assign s_axil_rvalid_o = (r_state == e_resp) & ~r_is_wr;
    assign s_axil_bresp_o  = r_resp;
    assign s_axil_rresp_o  = r_resp;
    assign s_axil_rdata_o  = r_rdata;

endmodule

// File: tb/tb_axil_slave_adaptor.sv
// Self-checking bench for axil_slave_adaptor: a cycle table for the basic
// write/read timing, then directed sequences for ordering, arbitration,
// backpressure and mid-transaction reset.
module tb_axil_slave_adaptor;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [AW-1:0]   s_axil_awaddr_i;
    logic [2:0]      s_axil_awprot_i;
    logic            s_axil_awvalid_i;
    logic            s_axil_awready_o;
    logic [DW-1:0]   s_axil_wdata_i;
    logic [DW/8-1:0] s_axil_wstrb_i;
    logic            s_axil_wvalid_i;
    logic            s_axil_wready_o;
    logic [1:0]      s_axil_bresp_o;
    logic            s_axil_bvalid_o;
    logic            s_axil_bready_i;
    logic [AW-1:0]   s_axil_araddr_i;
    logic [2:0]      s_axil_arprot_i;
    logic            s_axil_arvalid_i;
    logic            s_axil_arready_o;
    logic [DW-1:0]   s_axil_rdata_o;
    logic [1:0]      s_axil_rresp_o;
    logic            s_axil_rvalid_o;
    logic            s_axil_rready_i;
    logic [AW-1:0]   addr_o;
    logic            wr_en_o;
    logic [DW-1:0]   wdata_o;
    logic [DW/8-1:0] wstrb_o;
    logic            v_o;
    logic            ready_and_i;
    logic            v_i;
    logic [DW-1:0]   rdata_i;
    logic            err_i;
    logic            yumi_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    axil_slave_adaptor #(.axil_data_width_p(DW), .axil_addr_width_p(AW)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .s_axil_awaddr_i  (s_axil_awaddr_i),
        .s_axil_awprot_i  (s_axil_awprot_i),
        .s_axil_awvalid_i (s_axil_awvalid_i),
        .s_axil_awready_o (s_axil_awready_o),
        .s_axil_wdata_i   (s_axil_wdata_i),
        .s_axil_wstrb_i   (s_axil_wstrb_i),
        .s_axil_wvalid_i  (s_axil_wvalid_i),
        .s_axil_wready_o  (s_axil_wready_o),
        .s_axil_bresp_o   (s_axil_bresp_o),
        .s_axil_bvalid_o  (s_axil_bvalid_o),
        .s_axil_bready_i  (s_axil_bready_i),
        .s_axil_araddr_i  (s_axil_araddr_i),
        .s_axil_arprot_i  (s_axil_arprot_i),
        .s_axil_arvalid_i (s_axil_arvalid_i),
        .s_axil_arready_o (s_axil_arready_o),
        .s_axil_rdata_o   (s_axil_rdata_o),
        .s_axil_rresp_o   (s_axil_rresp_o),
        .s_axil_rvalid_o  (s_axil_rvalid_o),
        .s_axil_rready_i  (s_axil_rready_i),
        .addr_o           (addr_o),
        .wr_en_o          (wr_en_o),
        .wdata_o          (wdata_o),
        .wstrb_o          (wstrb_o),
        .v_o              (v_o),
        .ready_and_i      (ready_and_i),
        .v_i              (v_i),
        .rdata_i          (rdata_i),
        .err_i            (err_i),
        .yumi_o           (yumi_o)
    );

    // One cycle of the table: inputs applied, then outputs expected
    typedef struct {
        logic        awv, wv, arv;
        logic [31:0] addr, data;
        logic [3:0]  strb;
        logic        rdy, vi;
        logic [31:0] rd;
        logic        err, bready, rready;
        logic        e_awr, e_wr, e_arr, e_v, e_wren;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_y, e_b, e_r;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vec [12];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_b(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no handshake within bound, expected one at %0t", nm, $time);
    endtask

    task automatic clr_inputs();
        s_axil_awaddr_i  = '0; s_axil_awprot_i = 3'b101; s_axil_awvalid_i = 1'b0;
        s_axil_wdata_i   = '0; s_axil_wstrb_i  = '0;     s_axil_wvalid_i  = 1'b0;
        s_axil_araddr_i  = '0; s_axil_arprot_i = 3'b010; s_axil_arvalid_i = 1'b0;
        s_axil_bready_i  = 1'b0; s_axil_rready_i = 1'b0;
        ready_and_i = 1'b0; v_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        s_axil_awaddr_i  = a;
        s_axil_awvalid_i = 1'b1;
        while (!ok && n < 50) begin
            ok = s_axil_awready_o;
            tick();
            n++;
        end
        s_axil_awvalid_i = 1'b0;
        if (!ok) timeout_fail("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        s_axil_wdata_i  = d;
        s_axil_wstrb_i  = s;
        s_axil_wvalid_i = 1'b1;
        while (!ok && n < 50) begin
            ok = s_axil_wready_o;
            tick();
            n++;
        end
        s_axil_wvalid_i = 1'b0;
        if (!ok) timeout_fail("w_handshake");
    endtask

    task automatic send_ar(input logic [31:0] a);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        s_axil_araddr_i  = a;
        s_axil_arvalid_i = 1'b1;
        while (!ok && n < 50) begin
            ok = s_axil_arready_o;
            tick();
            n++;
        end
        s_axil_arvalid_i = 1'b0;
        if (!ok) timeout_fail("ar_handshake");
    endtask

    // Host side: wait for a request, check it, optionally stall, respond,
    // then check and accept the AXI response.
    task automatic host_serve(input logic exp_wr, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                              input logic [31:0] rd, input logic er, input int stall);
        int n;
        logic [1:0] exp_resp;
        n = 0;
        while (!v_o && n < 50) begin
            tick();
            n++;
        end
        if (!v_o) begin
            timeout_fail("host_req");
            return;
        end
        check_b("req_wr_en", wr_en_o, exp_wr);
        check_w("req_addr", addr_o, exp_addr);
        if (exp_wr) begin
            check_w("req_wdata", wdata_o, exp_wdata);
            check_w("req_wstrb", 32'(wstrb_o), 32'(exp_wstrb));
        end
        for (int k = 0; k < stall; k++) begin
            ready_and_i = 1'b0;
            tick();
            check_b("stall_v_o", v_o, 1'b1);
            check_w("stall_addr", addr_o, exp_addr);
            if (exp_wr) begin
                check_b("stall_awready", s_axil_awready_o, 1'b0);
                check_b("stall_wready", s_axil_wready_o, 1'b0);
            end
        end
        ready_and_i = 1'b1;
        tick();
        ready_and_i = 1'b0;
        check_b("req_drop", v_o, 1'b0);
        v_i = 1'b1; rdata_i = rd; err_i = er;
        #1;
        check_b("yumi", yumi_o, 1'b1);
        tick();
        v_i = 1'b0; err_i = 1'b0;
        exp_resp = er ? 2'b10 : 2'b00;
        if (exp_wr) begin
            check_b("bvalid", s_axil_bvalid_o, 1'b1);
            check_b("rvalid_idle", s_axil_rvalid_o, 1'b0);
            check_w("bresp", 32'(s_axil_bresp_o), 32'(exp_resp));
            s_axil_bready_i = 1'b1;
            tick();
            s_axil_bready_i = 1'b0;
            check_b("bvalid_drop", s_axil_bvalid_o, 1'b0);
        end else begin
            check_b("rvalid", s_axil_rvalid_o, 1'b1);
            check_b("bvalid_idle", s_axil_bvalid_o, 1'b0);
            check_w("rresp", 32'(s_axil_rresp_o), 32'(exp_resp));
            check_w("rdata", s_axil_rdata_o, rd);
            s_axil_rready_i = 1'b1;
            tick();
            s_axil_rready_i = 1'b0;
            check_b("rvalid_drop", s_axil_rvalid_o, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // awv wv arv addr data strb | rdy vi rd err bready rready ||
        // awr wr arr v wren addr wdata wstrb | y b r resp rdata
        vec[0]  = '{1'b1,1'b1,1'b0,32'h10,32'hDEADBEEF,4'hF, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,2'b00,32'h0};
        vec[1]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b0,1'b0,1'b1,1'b1,1'b1,32'h10,32'hDEADBEEF,4'hF, 1'b0,1'b0,1'b0,2'b00,32'h0};
        vec[2]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,1'b0,2'b00,32'h0};
        vec[3]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0,1'b1,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,1'b0,2'b00,32'h0};
        vec[4]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,2'b00,32'h0};
        vec[5]  = '{1'b0,1'b0,1'b1,32'h40,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,2'b00,32'h0};
        vec[6]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b0,1'b1,1'b0,32'h40,32'h0,4'h0, 1'b0,1'b0,1'b0,2'b00,32'h0};
        vec[7]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h12345678,1'b1,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,1'b0,2'b00,32'h0};
        vec[8]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b1,2'b10,32'h12345678};
        vec[9]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b1,2'b10,32'h12345678};
        vec[10] = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b1,2'b10,32'h12345678};
        vec[11] = '{1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,
                    1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,2'b00,32'h0};

        // Reset state
        clr_inputs();
        reset_n_i = 1'b0;
        #1;
        check_b("rst_awready", s_axil_awready_o, 1'b0);
        check_b("rst_arready", s_axil_arready_o, 1'b0);
        check_b("rst_v_o", v_o, 1'b0);
        check_b("rst_bvalid", s_axil_bvalid_o, 1'b0);
        check_b("rst_rvalid", s_axil_rvalid_o, 1'b0);
        tick(); tick(); tick();
        reset_n_i = 1'b1;
        tick();
        check_b("post_rst_awready", s_axil_awready_o, 1'b1);
        check_b("post_rst_wready", s_axil_wready_o, 1'b1);
        check_b("post_rst_arready", s_axil_arready_o, 1'b1);

        // Table: minimum-latency write, then read with SLVERR and rready held off
        for (int i = 0; i < 12; i++) begin
            tick();
            s_axil_awvalid_i = vec[i].awv; s_axil_awaddr_i = vec[i].addr;
            s_axil_wvalid_i  = vec[i].wv;  s_axil_wdata_i  = vec[i].data; s_axil_wstrb_i = vec[i].strb;
            s_axil_arvalid_i = vec[i].arv; s_axil_araddr_i = vec[i].addr;
            ready_and_i = vec[i].rdy; v_i = vec[i].vi; rdata_i = vec[i].rd; err_i = vec[i].err;
            s_axil_bready_i = vec[i].bready; s_axil_rready_i = vec[i].rready;
            #1;
            check_b($sformatf("awready[%0d]", i), s_axil_awready_o, vec[i].e_awr);
            check_b($sformatf("wready[%0d]", i),  s_axil_wready_o,  vec[i].e_wr);
            check_b($sformatf("arready[%0d]", i), s_axil_arready_o, vec[i].e_arr);
            check_b($sformatf("v_o[%0d]", i),     v_o,              vec[i].e_v);
            check_b($sformatf("yumi[%0d]", i),    yumi_o,           vec[i].e_y);
            check_b($sformatf("bvalid[%0d]", i),  s_axil_bvalid_o,  vec[i].e_b);
            check_b($sformatf("rvalid[%0d]", i),  s_axil_rvalid_o,  vec[i].e_r);
            if (vec[i].e_v) begin
                check_b($sformatf("wr_en[%0d]", i), wr_en_o, vec[i].e_wren);
                check_w($sformatf("addr[%0d]", i),  addr_o,  vec[i].e_addr);
                if (vec[i].e_wren) begin
                    check_w($sformatf("wdata[%0d]", i), wdata_o, vec[i].e_wdata);
                    check_w($sformatf("wstrb[%0d]", i), 32'(wstrb_o), 32'(vec[i].e_wstrb));
                end
            end
            if (vec[i].e_b) check_w($sformatf("bresp[%0d]", i), 32'(s_axil_bresp_o), 32'(vec[i].e_resp));
            if (vec[i].e_r) begin
                check_w($sformatf("rresp[%0d]", i), 32'(s_axil_rresp_o), 32'(vec[i].e_resp));
                check_w($sformatf("rdata[%0d]", i), s_axil_rdata_o, vec[i].e_rdata);
            end
        end
        clr_inputs();
        tick();

        // Round-robin: write and read pending together, twice -> W, R, W, R
        fork
            send_aw(32'h100);
            send_w(32'h11112222, 4'hF);
            send_ar(32'h200);
        join
        fork
            host_serve(1'b1, 32'h100, 32'h11112222, 4'hF, 32'h0, 1'b0, 0);
            send_aw(32'h104);
            send_w(32'h33334444, 4'h0);
        join
        fork
            host_serve(1'b0, 32'h200, 32'h0, 4'h0, 32'hAAAA0001, 1'b0, 0);
            send_ar(32'h204);
        join
        host_serve(1'b1, 32'h104, 32'h33334444, 4'h0, 32'h0, 1'b1, 0);
        host_serve(1'b0, 32'h204, 32'h0, 4'h0, 32'hBBBB0002, 1'b0, 0);
        tick();

        // W three cycles ahead of AW: nothing issued until AW lands
        send_w(32'hCAFEF00D, 4'h5);
        for (int k = 0; k < 3; k++) begin
            check_b("w_first_v_o", v_o, 1'b0);
            check_b("w_first_wready", s_axil_wready_o, 1'b0);
            tick();
        end
        send_aw(32'h20);
        check_b("aw_late_v_o", v_o, 1'b1);
        host_serve(1'b1, 32'h20, 32'hCAFEF00D, 4'h5, 32'h0, 1'b0, 0);
        tick();

        // Host backpressure for five cycles
        fork
            send_aw(32'h50);
            send_w(32'h0BADCAFE, 4'hC);
        join
        host_serve(1'b1, 32'h50, 32'h0BADCAFE, 4'hC, 32'hA5A50000, 1'b1, 5);
        tick();

        // Reset asserted while waiting on the host response
        fork
            send_aw(32'h60);
            send_w(32'h60606060, 4'hF);
        join
        check_b("pre_rst_v_o", v_o, 1'b1);
        ready_and_i = 1'b1;
        tick();
        ready_and_i = 1'b0;
        v_i = 1'b1;
        rdata_i = 32'h77777777;
        reset_n_i = 1'b0;
        #1;
        check_b("mid_rst_yumi", yumi_o, 1'b0);
        check_b("mid_rst_v_o", v_o, 1'b0);
        check_b("mid_rst_awready", s_axil_awready_o, 1'b0);
        check_b("mid_rst_wready", s_axil_wready_o, 1'b0);
        check_b("mid_rst_arready", s_axil_arready_o, 1'b0);
        check_b("mid_rst_bvalid", s_axil_bvalid_o, 1'b0);
        check_b("mid_rst_rvalid", s_axil_rvalid_o, 1'b0);
        check_w("mid_rst_rdata", s_axil_rdata_o, 32'h0);
        check_w("mid_rst_bresp", 32'(s_axil_bresp_o), 32'h0);
        v_i = 1'b0;
        rdata_i = '0;
        tick(); tick();
        reset_n_i = 1'b1;
        tick();
        check_b("rel_awready", s_axil_awready_o, 1'b1);
        check_b("rel_wready", s_axil_wready_o, 1'b1);
        check_b("rel_arready", s_axil_arready_o, 1'b1);
        check_b("rel_v_o", v_o, 1'b0);
        fork
            send_aw(32'h70);
            send_w(32'h70707070, 4'h3);
        join
        host_serve(1'b1, 32'h70, 32'h70707070, 4'h3, 32'h0, 1'b0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_slave_adaptor.md
Name: axil_slave_adaptor

Overview:
- AXI4-Lite subordinate (responder) front end. Converts AXI4-Lite read and write transactions from a PS/host master into a single-outstanding, valid/ready request and response interface for local fabric such as CSR banks and the BP bridge.
- It is the mirror of the team's AXI4-Lite master adaptor.
- The AW, W and AR channels are each buffered independently. Writes and reads are arbitrated fairly, one transaction at a time.

Parameters:
- axil_data_width_p, 32, AXI/host data width; only 32 or 64 are legal, anything else is an elaboration $error.
- axil_addr_width_p, 32, AXI/host address width.

Ports:
- clk_i  in  1  single clock
- reset_n_i  in  1  asynchronous, active-low reset
- s_axil_awaddr_i  in  addr_w  write address
- s_axil_awprot_i  in  3  ignored
- s_axil_awvalid_i  in  1  write address valid
- s_axil_awready_o  out  1  write address ready
- s_axil_wdata_i  in  data_w  write data
- s_axil_wstrb_i  in  data_w/8  write byte strobes
- s_axil_wvalid_i  in  1  write data valid
- s_axil_wready_o  out  1  write data ready
- s_axil_bresp_o  out  2  write response code
- s_axil_bvalid_o  out  1  write response valid
- s_axil_bready_i  in  1  write response ready
- s_axil_araddr_i  in  addr_w  read address
- s_axil_arprot_i  in  3  ignored
- s_axil_arvalid_i  in  1  read address valid
- s_axil_arready_o  out  1  read address ready
- s_axil_rdata_o  out  data_w  read data
- s_axil_rresp_o  out  2  read response code
- s_axil_rvalid_o  out  1  read data valid
- s_axil_rready_i  in  1  read data ready
- addr_o  out  addr_w  host request address
- wr_en_o  out  1  1 = write, 0 = read
- wdata_o  out  data_w  host write data
- wstrb_o  out  data_w/8  host write strobes
- v_o  out  1  host request valid
- ready_and_i  in  1  host accepts request
- v_i  in  1  host response valid
- rdata_i  in  data_w  host read data
- err_i  in  1  host error, qualified by v_i
- yumi_o  out  1  host response consumed

Behaviour:
- Reset: clk_i is the only clock. Reset is asynchronous, active-low (reset_n_i). Assertion takes effect immediately, even mid-transaction: all buffers are emptied, FSM goes to e_idle, and awready/wready/arready/bvalid/rvalid/v_o/yumi_o are all 0. Data and resp outputs reset to 0. Any in-flight host request is abandoned.
- Channel buffers: AW, W and AR each have a one-entry register plus a full flag.
  - ready_o = ~full. There is no combinational path from valid to ready.
  - A handshake (valid & ready) captures the payload and sets full.
  - AW and W may arrive in any order or in the same cycle.
  - A buffer is freed only when the FSM issues that transaction, i.e. the host request handshake.
- FSM states: e_idle, e_req, e_wait, e_resp.
  - e_idle: a write is eligible when aw_full & w_full; a read is eligible when ar_full.
    - If both are eligible, pick the opposite of last_wr_r (round-robin). last_wr_r resets to 0, so the first tie goes to the write.
    - Latch the choice into is_wr_r and go to e_req.
  - e_req: v_o = 1; drive addr/wr_en/wdata/wstrb from the buffers.
    - On v_o & ready_and_i: free the used buffers (AW+W, or AR), update last_wr_r, go to e_wait.
  - e_wait: yumi_o = v_i. The response is never sampled in the same cycle as the request handshake.
    - On v_i: capture rdata_i and resp = err_i ? 2'b10 (SLVERR) : 2'b00 (OKAY). Go to e_resp.
  - e_resp: bvalid = is_wr_r, or rvalid = ~is_wr_r.
    - Payload stays stable until bready/rready. On handshake go to e_idle.
  - bresp/rresp = 2'b11 (DECERR) is never generated.
- Minimum write latency:
  - cycle 0: AW and W handshake
  - cycle 1: v_o, with ready_and_i = 1
  - cycle 2: v_i
  - cycle 3: bvalid
- Reads take the same latency starting from the AR handshake.
- New AW/W/AR may be accepted while another transaction is in flight, as long as its buffer is empty. This gives at most one pending write plus one pending read.
- Simultaneous events:
  - A buffer freed in e_req does not reassert ready until the next cycle.
  - The cycle after e_resp, e_idle issues from the current buffer contents.
- AxPROT is ignored. wstrb passes through unmodified, including 0.

Decomposition:
- Package axil_pkg:
  - FSM state enum
  - resp codes e_axil_resp_okay = 2'b00 and e_axil_resp_slverr = 2'b10
  - e_axi_prot_default = 3'b000
- Sub-module axil_chan_buf (width_p): one-entry register with full flag, ready_o = ~full, yumi_i to free. Instantiated three times, for AW, W and AR.

Test Plan:
- Write with AW and W in the same cycle: addr 0x10, data 0xDEADBEEF, strb 0xF. Host ready immediately, responds next cycle with err = 0 → v_o at cycle 1 carrying the same values; bvalid at cycle 3 with bresp 00.
- W arrives 3 cycles before AW (addr 0x20) → no v_o until AW is captured; wready stays low after the capture; request is issued the cycle after the AW handshake.
- Read of addr 0x40 with host rdata 0x12345678, err = 1, rready held low for 2 cycles → rvalid held with rdata 0x12345678 and rresp 10 until rready.
- Write and read pending simultaneously, twice back-to-back → issue order write, read, write, read (round-robin); each bvalid/rvalid matches its own request.
- Backpressure: ready_and_i low for 5 cycles → v_o and addr stable; awready/wready stay 0 while the buffers are full.
- reset_n_i asserted during e_wait → all valids/readies drop 0 asynchronously; after release, awready/wready/arready = 1 and a new write completes normally.
